// File: rtl/laststage_mc.sv
// -----------------------------------------------------------------------------
// laststage_mc
//   Final radix-2 butterfly of the pipelined FFT across NCH channels.
//   It computes left = a + b and right = a - b on complex samples. A shift
//   that is latched once per frame scales the result. The scaled value is
//   then rounded half-to-even and saturated to OWIDTH. The block also tracks
//   the frame position (o_last) and a sticky per-frame overflow flag (o_ovf).
//   Latency is 3 enabled cycles: add/sub, scale/round/saturate, output reg.
//
// Ports
//   i_clk, i_reset_n  rising-edge clock, synchronous active-low reset
//   i_clk_enable      advances every piece of state when high
//   i_sync            first pair of a frame; also latches i_shift
//   i_shift           right-shift amount, clamped to MAXSHIFT
//   i_left, i_right   even / odd samples, channel k at [k*2*IWIDTH +: 2*IWIDTH],
//                     real part in the upper half
//   o_left, o_right   sums / differences, same packing at OWIDTH
//   o_sync, o_last    first / final pair of a frame, aligned with the data
//   o_ovf             saturation seen so far in the current output frame
// -----------------------------------------------------------------------------
module laststage_mc #(
  parameter int IWIDTH   = 16,
  parameter int OWIDTH   = 16,
  parameter int NCH      = 1,
  parameter int LGFFT    = 12,
  parameter int MAXSHIFT = 3,
  parameter int SW       = $clog2(MAXSHIFT + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_clk_enable,
  input  logic                    i_sync,
  input  logic [SW-1:0]           i_shift,
  input  logic [NCH*2*IWIDTH-1:0] i_left,
  input  logic [NCH*2*IWIDTH-1:0] i_right,
  output logic [NCH*2*OWIDTH-1:0] o_left,
  output logic [NCH*2*OWIDTH-1:0] o_right,
  output logic                    o_sync,
  output logic                    o_last,
  output logic                    o_ovf
);

  // The real and imaginary parts get identical arithmetic, so the datapath
  // treats every component as an independent lane. This keeps the packing.
  localparam int W1 = IWIDTH + 1;
  localparam int NL = 2 * NCH;
  localparam int CW = LGFFT - 1;

  localparam logic [CW-1:0]        CNT_TERM = '1;
  localparam logic signed [W1:0]   OMAX     = (W1 + 1)'(2 ** (OWIDTH - 1) - 1);
  localparam logic signed [W1:0]   OMIN     = (W1 + 1)'(-(2 ** (OWIDTH - 1)));

  typedef enum logic {FRM_IDLE, FRM_RUN} frm_state_t;

  function automatic logic signed [W1-1:0] sext(input logic [IWIDTH-1:0] v);
    return {v[IWIDTH-1], v};
  endfunction

  // Arithmetic shift right with round-half-to-even, then clamp to OWIDTH.
  // The work is done one bit wider than x so the round-up increment has room.
  function automatic logic [OWIDTH-1:0] scale_sat(
    input  logic signed [W1-1:0] x,
    input  logic [SW-1:0]        s,
    output logic                 ovf
  );
    logic signed [W1:0] q;
    logic [W1:0]        mask;
    logic [W1:0]        rem;
    logic [W1:0]        half;
    ovf  = 1'b0;
    q    = {x[W1-1], x};
    mask = ~({(W1 + 1){1'b1}} << s);
    rem  = q & mask;
    half = (s == '0) ? '0 : ((W1 + 1)'(1) << (s - SW'(1)));
    q    = q >>> s;
    // Above half rounds up. Exactly half rounds up only when that makes q even.
    if ((s != '0) && ((rem > half) || ((rem == half) && q[0])))
      q = q + (W1 + 1)'(1);
    if (q > OMAX) begin
      ovf = 1'b1;
      q   = OMAX;
    end else if (q < OMIN) begin
      ovf = 1'b1;
      q   = OMIN;
    end
    return OWIDTH'(q);
  endfunction

  // ---------------------------------------------------------------------------
  // Shift selection: a new value is taken only on a sync pair. That pair uses
  // the new value at once, so the shift travels down the pipe with its data.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] shift_q;
  logic [SW:0]   shift_ext;
  logic [SW-1:0] shift_new;
  logic [SW-1:0] shift_cur;

  always_comb begin
    shift_ext = {1'b0, i_shift};
    shift_new = (shift_ext > (SW + 1)'(MAXSHIFT)) ? SW'(MAXSHIFT) : i_shift;
    shift_cur = i_sync ? shift_new : shift_q;
  end

  // ---------------------------------------------------------------------------
  // Frame position FSM (input side). frm_cnt holds the index of the next pair.
  // ---------------------------------------------------------------------------
  frm_state_t    frm_state, frm_state_nxt;
  logic [CW-1:0] frm_cnt;
  logic          in_last;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)        frm_state <= FRM_IDLE;
    else if (i_clk_enable) frm_state <= frm_state_nxt;
  end

  always_comb begin
    frm_state_nxt = frm_state;
    if (i_sync)
      frm_state_nxt = FRM_RUN;
    else if ((frm_state == FRM_RUN) && (frm_cnt == CNT_TERM))
      frm_state_nxt = FRM_IDLE;
  end

  // A sync on the terminal pair starts a new frame instead of ending one.
  always_comb begin
    in_last = (frm_state == FRM_RUN) && !i_sync && (frm_cnt == CNT_TERM);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      frm_cnt <= '0;
    end else if (i_clk_enable) begin
      if (i_sync)                     frm_cnt <= CW'(1);
      else if (frm_state == FRM_RUN)  frm_cnt <= frm_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: full-precision add/sub per lane.
  // ---------------------------------------------------------------------------
  logic signed [W1-1:0] st1_sum [NL];
  logic signed [W1-1:0] st1_dif [NL];
  logic signed [W1-1:0] s1_sum  [NL];
  logic signed [W1-1:0] s1_dif  [NL];
  logic                 s1_sync, s1_last;
  logic [SW-1:0]        s1_shift;

  always_comb begin
    for (int j = 0; j < NL; j++) begin
      st1_sum[j] = sext(i_left[j*IWIDTH +: IWIDTH]) + sext(i_right[j*IWIDTH +: IWIDTH]);
      st1_dif[j] = sext(i_left[j*IWIDTH +: IWIDTH]) - sext(i_right[j*IWIDTH +: IWIDTH]);
    end
  end

  // NOTE: register state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let stage 2 see stage 1's new data.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      // NOTE: these arrays are pipeline registers and not RAM, so they are
      // reset like any other flop and come out of reset with clean zero data.
      for (int j = 0; j < NL; j++) begin
        s1_sum[j] <= '0;
        s1_dif[j] <= '0;
      end
      s1_sync  <= 1'b0;
      s1_last  <= 1'b0;
      s1_shift <= '0;
      shift_q  <= '0;
    end else if (i_clk_enable) begin
      for (int j = 0; j < NL; j++) begin
        s1_sum[j] <= st1_sum[j];
        s1_dif[j] <= st1_dif[j];
      end
      s1_sync  <= i_sync;
      s1_last  <= in_last;
      s1_shift <= shift_cur;
      shift_q  <= shift_cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: scale, round, saturate. A clamp in any lane flags the sample.
  // ---------------------------------------------------------------------------
  logic [NL*OWIDTH-1:0] st2_left, st2_right;
  logic [NL-1:0]        ovf_l, ovf_r;
  logic [NL*OWIDTH-1:0] s2_left, s2_right;
  logic                 s2_sync, s2_last, s2_ovf;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch can be inferred.
    st2_left  = '0;
    st2_right = '0;
    ovf_l     = '0;
    ovf_r     = '0;
    for (int j = 0; j < NL; j++) begin
      st2_left[j*OWIDTH +: OWIDTH]  = scale_sat(s1_sum[j], s1_shift, ovf_l[j]);
      st2_right[j*OWIDTH +: OWIDTH] = scale_sat(s1_dif[j], s1_shift, ovf_r[j]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s2_left  <= '0;
      s2_right <= '0;
      s2_sync  <= 1'b0;
      s2_last  <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (i_clk_enable) begin
      s2_left  <= st2_left;
      s2_right <= st2_right;
      s2_sync  <= s1_sync;
      s2_last  <= s1_last;
      s2_ovf   <= |{ovf_l, ovf_r};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: output register. o_ovf restarts on the sync sample and then
  // accumulates, so on o_last it covers the whole frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_left  <= '0;
      o_right <= '0;
      o_sync  <= 1'b0;
      o_last  <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (i_clk_enable) begin
      o_left  <= s2_left;
      o_right <= s2_right;
      o_sync  <= s2_sync;
      o_last  <= s2_last;
      o_ovf   <= s2_sync ? s2_ovf : (o_ovf | s2_ovf);
    end
  end

endmodule
